// File: rtl/mem_beat_ctrl.sv
// mem_beat_ctrl: maps byte/half/word/dword accesses onto a BYTES-wide bus with lane enables and load extension.
// Define UNALIGNED_SPLIT_EN to run misaligned accesses as one or two beats instead of raising ade.
module mem_beat_ctrl #(
   parameter int          DATA_W  = 32,
   parameter logic [31:0] MMIO_LO = 32'h00007f00,
   parameter logic [31:0] MMIO_HI = 32'h00007f1b
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [31:0]         req_addr,
   input  logic [1:0]          req_size,
   input  logic                req_we,
   input  logic                req_signed,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                bus_valid,
   input  logic                bus_ready,
   output logic [31:0]         bus_addr,
   output logic [DATA_W/8-1:0] bus_be,
   output logic                bus_we,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                ade,
   output logic [31:0]         ade_addr
);
   localparam int BYTES = DATA_W/8;
   localparam int OFFW = $clog2(BYTES);
   localparam logic [1:0] IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3;
   logic [1:0]        r_state;
   logic [31:0]       r_addr, r_ade_addr;
   logic [1:0]        r_size;
   logic              r_we, r_signed, r_ade;
   logic [DATA_W-1:0] r_wdata, r_d0;
   logic [3:0]        w_nbytes;
   logic [OFFW-1:0]   w_off, w_roff;
   logic [32:0]       w_last;
   logic              w_dev_err, w_size_err, w_err, w_in_b1;
   logic [DATA_W-1:0] w_rot, w_sh, w_keep, w_hi;
   logic [7:0]        w_mask, w_bits;
   logic [2*BYTES-1:0] w_be2;
   logic              w_sgn;
`ifdef UNALIGNED_SPLIT_EN
   logic              r_split, w_split;
   logic [DATA_W-1:0] r_d1;
   assign w_split = (5'(w_off) + 5'(w_nbytes)) > 5'(BYTES);
   // a split whose second beat would wrap the 32-bit address space is illegal
   assign w_err = w_size_err | w_dev_err | (w_split & w_last[32]);
   assign w_in_b1 = r_state == BEAT1;
   assign w_hi = r_d1;
`else
   assign w_err = w_size_err | w_dev_err | ((req_addr[2:0] & 3'(w_nbytes - 4'd1)) != 3'd0);
   assign w_in_b1 = 1'b0;
   assign w_hi = '0;
`endif
   assign w_nbytes = 4'd1 << req_size;
   assign w_off = req_addr[OFFW-1:0];
   assign w_last = {1'b0, req_addr} + 33'(w_nbytes) - 33'd1;
   assign w_dev_err = (req_addr <= MMIO_HI) && (w_last >= {1'b0, MMIO_LO}) &&
                      !(req_size == 2'd2 && req_addr[1:0] == 2'b00);
   assign w_size_err = (req_size == 2'd3) && (BYTES == 4);
   assign w_rot = DATA_W'({req_wdata, req_wdata} >> (DATA_W - 8*int'(w_off)));
   assign w_roff = r_addr[OFFW-1:0];
   assign w_mask = r_size == 2'd0 ? 8'h01 : r_size == 2'd1 ? 8'h03 : r_size == 2'd2 ? 8'h0f : 8'hff;
   assign w_be2 = (2*BYTES)'(w_mask) << w_roff;
   assign w_bits = 8'd8 << r_size;
   // beat1 lanes sit above beat0 lanes, so one right shift right-justifies the load
   assign w_sh = DATA_W'({w_hi, r_d0} >> {w_roff, 3'b000});
   assign w_keep = ~({DATA_W{1'b1}} << w_bits);
   assign w_sgn = r_size == 2'd0 ? w_sh[7] : r_size == 2'd1 ? w_sh[15] : r_size == 2'd2 ? w_sh[31] : w_sh[DATA_W-1];
   assign req_ready = r_state == IDLE;
   assign bus_valid = r_state == BEAT0 || w_in_b1;
   assign bus_addr = w_in_b1 ? {r_addr[31:OFFW], {OFFW{1'b0}}} + 32'(BYTES) :
                     r_state == BEAT0 ? {r_addr[31:OFFW], {OFFW{1'b0}}} : 32'd0;
   assign bus_be = w_in_b1 ? w_be2[2*BYTES-1:BYTES] : r_state == BEAT0 ? w_be2[BYTES-1:0] : '0;
   assign bus_we = r_we;
   assign bus_wdata = r_wdata;
   assign rsp_valid = r_state == RESP;
   assign rsp_rdata = (r_state == RESP && !r_we) ? (w_sh & w_keep) | ({DATA_W{r_signed & w_sgn}} & ~w_keep) : '0;
   assign ade = r_ade;
   assign ade_addr = r_ade_addr;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_addr <= '0;
         r_size <= '0;
         r_we <= 1'b0;
         r_signed <= 1'b0;
         r_wdata <= '0;
         r_d0 <= '0;
         r_ade <= 1'b0;
         r_ade_addr <= '0;
`ifdef UNALIGNED_SPLIT_EN
         r_split <= 1'b0;
         r_d1 <= '0;
`endif
      end else begin
         r_ade <= 1'b0;
         case (r_state)
            IDLE: if (req_valid) begin
               r_addr <= req_addr;
               r_size <= req_size;
               r_we <= req_we;
               r_signed <= req_signed;
               r_wdata <= w_rot;
`ifdef UNALIGNED_SPLIT_EN
               r_split <= w_split;
`endif
               if (w_err) begin
                  r_ade <= 1'b1;
                  r_ade_addr <= req_addr;
               end else r_state <= BEAT0;
            end
            BEAT0: if (bus_ready) begin
               r_d0 <= bus_rdata;
`ifdef UNALIGNED_SPLIT_EN
               r_state <= r_split ? BEAT1 : RESP;
`else
               r_state <= RESP;
`endif
            end
`ifdef UNALIGNED_SPLIT_EN
            BEAT1: if (bus_ready) begin
               r_d1 <= bus_rdata;
               r_state <= RESP;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_beat_ctrl.sv
// tb_mem_beat_ctrl: directed vectors; expected bus beats, responses and ade pulses are queued and
// checked by an independent monitor, including their cycle offset from request acceptance.
module tb_mem_beat_ctrl;
   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] data;
      int          off;
   } exp_t;
   logic        clk = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, bus_ready = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0, rd0 = '0, rd1 = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, bus_valid, bus_we, rsp_valid, ade;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, rsp_rdata, ade_addr;
   logic [3:0]  bus_be;
   logic        v_valid = 1'b0, v_ready, v_bvalid, v_bwe, v_rsp, v_ade;
   logic [31:0] v_addr = '0, v_baddr, v_ade_addr;
   logic [7:0]  v_be;
   logic [63:0] v_bwdata, v_rdata;
   int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, beats_seen = 0, beats_base = 0;
   exp_t q[$];
   mem_beat_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_size(req_size), .req_we(req_we), .req_signed(req_signed), .req_wdata(req_wdata),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .ade(ade), .ade_addr(ade_addr)
   );
   mem_beat_ctrl #(.DATA_W(64)) dut64 (
      .clk(clk), .reset(reset), .req_valid(v_valid), .req_ready(v_ready), .req_addr(v_addr),
      .req_size(2'd3), .req_we(1'b0), .req_signed(1'b0), .req_wdata(64'd0),
      .bus_valid(v_bvalid), .bus_ready(1'b1), .bus_addr(v_baddr), .bus_be(v_be),
      .bus_we(v_bwe), .bus_wdata(v_bwdata), .bus_rdata(64'd0), .rsp_valid(v_rsp),
      .rsp_rdata(v_rdata), .ade(v_ade), .ade_addr(v_ade_addr)
   );
   always #5 clk = ~clk;
   assign bus_rdata = (beats_seen == beats_base) ? rd0 : rd1;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus_valid && bus_ready) beats_seen <= beats_seen + 1;
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask
   task automatic observe(input int k, input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] d);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d actual addr=%h be=%h data=%h required none", k, a, be, d);
      end else begin
         e = q.pop_front();
         if (e.kind != k || (k != 1 && e.addr !== a) || (k == 0 && (e.be !== be || e.we !== we)) ||
             (k != 2 && e.data !== d) || (e.off >= 0 && cyc - acc_cyc != e.off)) begin
            failures++;
            $display("FAIL event actual kind=%0d addr=%h be=%h we=%b data=%h cyc=%0d required kind=%0d addr=%h be=%h we=%b data=%h cyc=%0d",
                     k, a, be, we, d, cyc - acc_cyc, e.kind, e.addr, e.be, e.we, e.data, e.off);
         end
      end
   endtask
   always @(negedge clk) if (!reset) begin
      if (bus_valid && bus_ready) observe(0, bus_addr, bus_be, bus_we, bus_wdata);
      if (rsp_valid) observe(1, 32'd0, 4'd0, 1'b0, rsp_rdata);
      if (ade) observe(2, ade_addr, 4'd0, 1'b0, 32'd0);
   end
   task automatic exp(input int k, input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] d, input int off);
      q.push_back('{kind: k, addr: a, be: be, we: we, data: d, off: off});
   endtask
   task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic we, input logic sg,
                        input logic [31:0] wd, input logic [31:0] r0, input logic [31:0] r1);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      rd0 = r0;
      rd1 = r1;
      beats_base = beats_seen;
      req_valid = 1'b1;
      req_addr = a;
      req_size = sz;
      req_we = we;
      req_signed = sg;
      req_wdata = wd;
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask
   task automatic drain(input string nm);
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_done"}, 64'(q.size()), 64'd0);
      q.delete();
      repeat (3) @(negedge clk);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outs", {bus_valid, rsp_valid, ade, bus_be, bus_addr, rsp_rdata}, 64'd0);
      chk("reset_ade_addr", {32'd0, ade_addr}, 64'd0);
      chk("reset_ready", {63'd0, req_ready}, 64'd1);
      reset = 1'b0;
      @(negedge clk);
      exp(0, 32'h1000, 4'b1000, 1'b1, 32'hAB000000, 1);
      exp(1, 0, 0, 0, 32'h0, 2);
      issue(32'h1003, 2'd0, 1'b1, 1'b0, 32'h000000AB, 0, 0);
      drain("byte_store");
      exp(0, 32'h2000, 4'b1100, 1'b0, 32'h0, 1);
      exp(1, 0, 0, 0, 32'hFFFF80FF, 2);
      issue(32'h2002, 2'd1, 1'b0, 1'b1, 0, 32'h80FF0000, 0);
      drain("half_load_s");
      exp(0, 32'h2000, 4'b1100, 1'b0, 32'h0, 1);
      exp(1, 0, 0, 0, 32'h000080FF, 2);
      issue(32'h2002, 2'd1, 1'b0, 1'b0, 0, 32'h80FF0000, 0);
      drain("half_load_u");
      exp(0, 32'h5000, 4'b0001, 1'b0, 32'h0, 1);
      exp(1, 0, 0, 0, 32'h0000007F, 2);
      issue(32'h5000, 2'd0, 1'b0, 1'b1, 0, 32'h1234567F, 0);
      drain("byte_load_pos");
      exp(0, 32'h5000, 4'b1000, 1'b0, 32'h0, 1);
      exp(1, 0, 0, 0, 32'hFFFFFF9A, 2);
      issue(32'h5003, 2'd0, 1'b0, 1'b1, 0, 32'h9A000000, 0);
      drain("byte_load_neg");
      exp(0, 32'h6000, 4'b1100, 1'b1, 32'hBEEFCAFE, 1);
      exp(1, 0, 0, 0, 32'h0, 2);
      issue(32'h6002, 2'd1, 1'b1, 1'b0, 32'hCAFEBEEF, 0, 0);
      drain("half_store");
      exp(0, 32'h7f04, 4'b1111, 1'b0, 32'h0, 1);
      exp(1, 0, 0, 0, 32'h12345678, 2);
      issue(32'h7f04, 2'd2, 1'b0, 1'b0, 0, 32'h12345678, 0);
      drain("mmio_word");
      exp(2, 32'h7f05, 0, 0, 0, 1);
      issue(32'h7f05, 2'd0, 1'b0, 1'b0, 0, 0, 0);
      drain("mmio_byte");
      exp(2, 32'h7f18, 0, 0, 0, 1);
      issue(32'h7f18, 2'd1, 1'b0, 1'b0, 0, 0, 0);
      drain("mmio_half");
      exp(2, 32'h7efe, 0, 0, 0, 1);
      issue(32'h7efe, 2'd2, 1'b0, 1'b0, 0, 0, 0);
      drain("mmio_straddle");
      exp(0, 32'h7f1c, 4'b1111, 1'b0, 32'h0, 1);
      exp(1, 0, 0, 0, 32'hA5A5A5A5, 2);
      issue(32'h7f1c, 2'd2, 1'b0, 1'b0, 0, 32'hA5A5A5A5, 0);
      drain("above_mmio");
      exp(2, 32'h8000, 0, 0, 0, 1);
      issue(32'h8000, 2'd3, 1'b0, 1'b0, 0, 0, 0);
      drain("dword_on_32");
      exp(2, 32'hFFFFFFFE, 0, 0, 0, 1);
      issue(32'hFFFFFFFE, 2'd2, 1'b0, 1'b0, 0, 0, 0);
      drain("wrap");
`ifdef UNALIGNED_SPLIT_EN
      exp(0, 32'h3000, 4'b1100, 1'b0, 32'h0, 1);
      exp(0, 32'h3004, 4'b0011, 1'b0, 32'h0, 2);
      exp(1, 0, 0, 0, 32'h44332211, 3);
      issue(32'h3002, 2'd2, 1'b0, 1'b0, 0, 32'h22110000, 32'h00004433);
      drain("split_word");
      exp(0, 32'h2000, 4'b0110, 1'b0, 32'h0, 1);
      exp(1, 0, 0, 0, 32'h0000ABCD, 2);
      issue(32'h2001, 2'd1, 1'b0, 1'b0, 0, 32'h00ABCD00, 0);
      drain("mis_half");
`else
      exp(2, 32'h3002, 0, 0, 0, 1);
      issue(32'h3002, 2'd2, 1'b0, 1'b0, 0, 0, 0);
      drain("split_word");
      exp(2, 32'h2001, 0, 0, 0, 1);
      issue(32'h2001, 2'd1, 1'b0, 1'b0, 0, 0, 0);
      drain("mis_half");
`endif
      bus_ready = 1'b0;
      issue(32'h4000, 2'd2, 1'b1, 1'b0, 32'h11223344, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         chk("stall_bus", {bus_valid, bus_we, bus_be, bus_addr[25:0], bus_wdata}, {1'b1, 1'b1, 4'hF, 26'h4000, 32'h11223344});
         chk("stall_ready", {63'd0, req_ready}, 64'd0);
         if (i < 3) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus_ready = 1'b1;
      chk("abort_bus_valid", {63'd0, bus_valid}, 64'd0);
      chk("abort_state", {req_ready, rsp_valid, ade_addr}, {2'b10, 32'd0});
      repeat (5) @(negedge clk);
      chk("abort_no_rsp", 64'(q.size()), 64'd0);
      v_valid = 1'b1;
      v_addr = 32'hFFFFFFFC;
      @(negedge clk);
      v_valid = 1'b0;
      chk("d64_ade", {v_ade, v_bvalid, v_rsp, v_ade_addr}, {3'b100, 32'hFFFFFFFC});
      @(negedge clk);
      chk("d64_ade_pulse", {v_ade, v_bvalid, v_rsp}, 3'b000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
